deadlock_cycle_reporter: RTL and testbench

- Collector end of the dataflow deadlock-detection token protocol.
- Receives per-process suspicion levels (dl_in_vec) and token-arrival strobes (trace_vld_vec) from N per-process detect units.
- Drives the broadcast controls back to those units: dl_detect_out (freeze), one-hot origin, token_clear.
- Confirms a dependency loop, traces the token round trip, then emits one report transaction per confirmed deadlock. Instantiated once per dataflow region in the simulation harness.

---
 rtl/deadlock_report_pkg.sv | 45 ++++
 rtl/deadlock_cycle_reporter_if.sv | 32 +++
 rtl/dl_prio_enc.sv | 25 ++
 rtl/deadlock_cycle_reporter.sv | 130 +++++++++++++
 tb/tb_deadlock_cycle_reporter.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/deadlock_report_pkg.sv
// Shared types and width helpers for the deadlock cycle reporter.
// Width helpers are constant functions so they can size ports.
package deadlock_report_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACE  = 2'd1,
        REPORT = 2'd2,
        CLEAR  = 2'd3
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((r < 31) && ((1 << r) < value)) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int at_least_one(input int value);
        return (value < 1) ? 1 : value;
    endfunction

    function automatic int idx_w(input int n);
        return at_least_one(clog2(n));
    endfunction

    function automatic int len_w(input int n);
        return at_least_one(clog2(n + 1));
    endfunction

    // Supports loops of up to 64 processes, which is far beyond any dataflow region.
    function automatic int popcount(input logic [63:0] bits);
        int count;
        count = 0;
        for (int i = 0; i < 64; i++) begin
            if (bits[i]) begin
                count = count + 1;
            end
        end
        return count;
    endfunction

endpackage

// File: rtl/deadlock_cycle_reporter_if.sv
// Report channel from the deadlock collector to its sink (valid/ready).
interface deadlock_cycle_reporter_if
    import deadlock_report_pkg::*;
#(
    parameter int N_PROC = 4
);
    localparam int IDXW = idx_w(N_PROC);
    localparam int LENW = len_w(N_PROC);

    logic            report_valid;
    logic            report_ready;
    logic [IDXW-1:0] report_origin;
    logic [N_PROC-1:0] report_mask;
    logic [LENW-1:0] report_len;

    modport master (
        output report_valid,
        output report_origin,
        output report_mask,
        output report_len,
        input  report_ready
    );

    modport slave (
        input  report_valid,
        input  report_origin,
        input  report_mask,
        input  report_len,
        output report_ready
    );

endinterface

// File: rtl/dl_prio_enc.sv
// Lowest-set-bit priority encoder used to pick the token origin.
module dl_prio_enc
    import deadlock_report_pkg::*;
#(
    parameter int N = 4,
    localparam int IDXW = idx_w(N)
) (
    input  logic [N-1:0]    req,
    output logic [IDXW-1:0] idx,
    output logic            any
);

    // Scan downward so the lowest requesting bit is the last one written.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDXW'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/deadlock_cycle_reporter.sv
// Collector end of the deadlock token protocol: confirm a suspected loop, trace
// the token round trip, and publish one report per confirmed deadlock.
module deadlock_cycle_reporter
    import deadlock_report_pkg::*;
#(
    parameter int N_PROC         = 4,
    parameter int CONFIRM_CYCLES = 2,
    parameter int TRACE_TIMEOUT  = 64,
    parameter int CNT_W          = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_PROC-1:0] dl_in_vec,
    input  logic [N_PROC-1:0] trace_vld_vec,
    output logic              dl_detect_out,
    output logic [N_PROC-1:0] origin,
    output logic              token_clear,
    output logic              deadlock_seen,
    output logic [CNT_W-1:0]  false_alarm_cnt,
    deadlock_cycle_reporter_if.master report
);

    localparam int IDXW = idx_w(N_PROC);
    localparam int LENW = len_w(N_PROC);
    localparam int TMRW = at_least_one(clog2(TRACE_TIMEOUT));
    localparam int CFW  = at_least_one(clog2(CONFIRM_CYCLES));

    localparam logic [CFW-1:0]  CONFIRM_LAST = CFW'(CONFIRM_CYCLES - 1);
    localparam logic [TMRW-1:0] TIMER_LAST   = TMRW'(TRACE_TIMEOUT - 1);

    state_t            state_reg;
    logic [CFW-1:0]    confirm_cnt_reg;
    logic [TMRW-1:0]   timer_reg;
    logic [N_PROC-1:0] mask_reg;
    logic [IDXW-1:0]   idx_reg;

    logic [IDXW-1:0]   enc_idx;
    logic              enc_any;
    logic [N_PROC-1:0] launch_onehot;
    logic [N_PROC-1:0] mask_next;
    logic              token_back;

    dl_prio_enc #(
        .N (N_PROC)
    ) u_prio_enc (
        .req (dl_in_vec),
        .idx (enc_idx),
        .any (enc_any)
    );

    assign launch_onehot = N_PROC'(1) << enc_idx;
    assign mask_next     = mask_reg | trace_vld_vec;
    // A strobe at the origin on the first TRACE cycle is the launch, not the return.
    assign token_back    = trace_vld_vec[idx_reg] && (timer_reg != '0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg            <= IDLE;
            confirm_cnt_reg      <= '0;
            timer_reg            <= '0;
            mask_reg             <= '0;
            idx_reg              <= '0;
            dl_detect_out        <= 1'b0;
            origin               <= '0;
            token_clear          <= 1'b0;
            deadlock_seen        <= 1'b0;
            false_alarm_cnt      <= '0;
            report.report_valid  <= 1'b0;
            report.report_origin <= '0;
            report.report_mask   <= '0;
            report.report_len    <= '0;
        end else begin
            token_clear <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!enc_any) begin
                        confirm_cnt_reg <= '0;
                    end else if (confirm_cnt_reg == CONFIRM_LAST) begin
                        idx_reg         <= enc_idx;
                        origin          <= launch_onehot;
                        dl_detect_out   <= 1'b1;
                        mask_reg        <= launch_onehot;
                        timer_reg       <= '0;
                        confirm_cnt_reg <= '0;
                        state_reg       <= TRACE;
                    end else begin
                        confirm_cnt_reg <= confirm_cnt_reg + 1'b1;
                    end
                end
                TRACE: begin
                    mask_reg  <= mask_next;
                    timer_reg <= timer_reg + 1'b1;
                    if (token_back) begin
                        report.report_origin <= idx_reg;
                        report.report_mask   <= mask_next;
                        report.report_len    <= LENW'(popcount(64'(mask_next)));
                        report.report_valid  <= 1'b1;
                        state_reg            <= REPORT;
                    end else if (timer_reg == TIMER_LAST) begin
                        if (false_alarm_cnt != '1) begin
                            false_alarm_cnt <= false_alarm_cnt + 1'b1;
                        end
                        token_clear <= 1'b1;
                        state_reg   <= CLEAR;
                    end
                end
                REPORT: begin
                    if (report.report_ready) begin
                        report.report_valid <= 1'b0;
                        deadlock_seen       <= 1'b1;
                        token_clear         <= 1'b1;
                        state_reg           <= CLEAR;
                    end
                end
                CLEAR: begin
                    dl_detect_out   <= 1'b0;
                    origin          <= '0;
                    confirm_cnt_reg <= '0;
                    mask_reg        <= '0;
                    timer_reg       <= '0;
                    state_reg       <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_deadlock_cycle_reporter.sv
// Scenario bench for deadlock_cycle_reporter with a report scoreboard and
// per-cycle protocol invariant checks.
module tb_deadlock_cycle_reporter;

    logic       clock;
    logic       reset;
    logic [3:0] dl_in_vec;
    logic [3:0] trace_vld_vec;
    logic       dl_detect_out;
    logic [3:0] origin;
    logic       token_clear;
    logic       deadlock_seen;
    logic [1:0] false_alarm_cnt;

    deadlock_cycle_reporter_if #(.N_PROC(4)) rpt ();

    deadlock_cycle_reporter #(
        .N_PROC         (4),
        .CONFIRM_CYCLES (2),
        .TRACE_TIMEOUT  (64),
        .CNT_W          (2)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .dl_in_vec       (dl_in_vec),
        .trace_vld_vec   (trace_vld_vec),
        .dl_detect_out   (dl_detect_out),
        .origin          (origin),
        .token_clear     (token_clear),
        .deadlock_seen   (deadlock_seen),
        .false_alarm_cnt (false_alarm_cnt),
        .report          (rpt)
    );

    typedef struct packed {
        logic [1:0] org;
        logic [3:0] mask;
        logic [2:0] len;
    } rep_t;

    rep_t       exp_q[$];
    int         vectors;
    int         miscompares;
    logic [1:0] exp_fa;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion within 200000 time units");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Scoreboard: each report handshake pops one expected report.
    always @(negedge clock) begin
        rep_t e;
        if (reset && rpt.report_valid && rpt.report_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL report_unexpected: got origin=%0d mask=%b len=%0d, required no report",
                         rpt.report_origin, rpt.report_mask, rpt.report_len);
            end else begin
                e = exp_q.pop_front();
                if ({rpt.report_origin, rpt.report_mask, rpt.report_len} !== e) begin
                    miscompares++;
                    $display("FAIL report_fields: got origin=%0d mask=%b len=%0d, required origin=%0d mask=%b len=%0d",
                             rpt.report_origin, rpt.report_mask, rpt.report_len, e.org, e.mask, e.len);
                end else begin
                    $display("report origin=%0d mask=%b len=%0d", e.org, e.mask, e.len);
                end
            end
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            vectors++;
            if (token_clear && rpt.report_valid) begin
                miscompares++;
                $display("FAIL clear_vs_valid: got token_clear=1 report_valid=1, required not both");
            end
            vectors++;
            if (dl_detect_out ? !$onehot(origin) : (origin != 4'b0000)) begin
                miscompares++;
                $display("FAIL origin_onehot: got origin=%b dl_detect_out=%b, required one-hot iff frozen",
                         origin, dl_detect_out);
            end
        end
    end

    task automatic test_reset();
        reset = 1'b0;
        dl_in_vec = '0;
        trace_vld_vec = '0;
        rpt.report_ready = 1'b0;
        exp_fa = 2'd0;
        repeat (3) @(negedge clock);
        vectors++;
        if ({dl_detect_out, origin, token_clear, rpt.report_valid, rpt.report_origin,
             rpt.report_mask, rpt.report_len, deadlock_seen, false_alarm_cnt} !== 20'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got det=%b org=%b clr=%b rv=%b ro=%0d rm=%b rl=%0d seen=%b fa=%0d, required all 0",
                     dl_detect_out, origin, token_clear, rpt.report_valid, rpt.report_origin,
                     rpt.report_mask, rpt.report_len, deadlock_seen, false_alarm_cnt);
        end
        reset = 1'b1;
        $display("reset released");
    endtask

    task automatic test_trace_report();
        rpt.report_ready = 1'b1;
        tick();
        dl_in_vec = 4'b0110;
        tick();
        @(negedge clock);
        vectors++;
        if (dl_detect_out !== 1'b0) begin
            miscompares++;
            $display("FAIL confirm_early: got dl_detect_out=%b, required 0 after one edge", dl_detect_out);
        end
        tick();
        dl_in_vec = 4'b0000;
        @(negedge clock);
        vectors++;
        if ({dl_detect_out, origin} !== {1'b1, 4'b0010}) begin
            miscompares++;
            $display("FAIL trace_entry: got det=%b origin=%b, required det=1 origin=0010", dl_detect_out, origin);
        end
        tick();
        trace_vld_vec = 4'b0100;
        tick();
        trace_vld_vec = 4'b1000;
        tick();
        trace_vld_vec = 4'b0000;
        tick();
        trace_vld_vec = 4'b0010;
        exp_q.push_back('{org: 2'd1, mask: 4'b1110, len: 3'd3});
        tick();
        trace_vld_vec = 4'b0000;
        @(negedge clock);
        vectors++;
        if ({rpt.report_valid, token_clear} !== 2'b10) begin
            miscompares++;
            $display("FAIL report_valid_rise: got rv=%b clr=%b, required rv=1 clr=0", rpt.report_valid, token_clear);
        end
        tick();
        @(negedge clock);
        vectors++;
        if ({rpt.report_valid, token_clear, deadlock_seen, dl_detect_out} !== 4'b0111) begin
            miscompares++;
            $display("FAIL after_handshake: got rv=%b clr=%b seen=%b det=%b, required rv=0 clr=1 seen=1 det=1",
                     rpt.report_valid, token_clear, deadlock_seen, dl_detect_out);
        end
        tick();
        @(negedge clock);
        vectors++;
        if ({token_clear, dl_detect_out, origin, rpt.report_mask, deadlock_seen} !== {1'b0, 1'b0, 4'b0000, 4'b1110, 1'b1}) begin
            miscompares++;
            $display("FAIL back_to_idle: got clr=%b det=%b org=%b rm=%b seen=%b, required clr=0 det=0 org=0000 rm=1110 seen=1",
                     token_clear, dl_detect_out, origin, rpt.report_mask, deadlock_seen);
        end
    endtask

    task automatic test_confirm_restart();
        tick();
        dl_in_vec = 4'b0001;
        tick();
        dl_in_vec = 4'b0000;
        tick();
        dl_in_vec = 4'b0001;
        tick();
        dl_in_vec = 4'b0000;
        repeat (3) tick();
        @(negedge clock);
        vectors++;
        if ({dl_detect_out, origin, token_clear, rpt.report_valid} !== 7'd0) begin
            miscompares++;
            $display("FAIL confirm_restart: got det=%b org=%b clr=%b rv=%b, required all 0",
                     dl_detect_out, origin, token_clear, rpt.report_valid);
        end
        $display("short pulses ignored");
    endtask

    task automatic test_timeout(input logic [3:0] launch);
        rpt.report_ready = 1'b1;
        tick();
        dl_in_vec = launch;
        tick();
        tick();
        dl_in_vec = 4'b0000;
        @(negedge clock);
        vectors++;
        if ({dl_detect_out, origin} !== {1'b1, launch}) begin
            miscompares++;
            $display("FAIL timeout_entry: got det=%b origin=%b, required det=1 origin=%b", dl_detect_out, origin, launch);
        end
        repeat (63) tick();
        @(negedge clock);
        vectors++;
        if ({dl_detect_out, token_clear, rpt.report_valid} !== 3'b100) begin
            miscompares++;
            $display("FAIL timeout_early: got det=%b clr=%b rv=%b, required det=1 clr=0 rv=0",
                     dl_detect_out, token_clear, rpt.report_valid);
        end
        exp_fa = (exp_fa == 2'd3) ? 2'd3 : exp_fa + 2'd1;
        tick();
        @(negedge clock);
        vectors++;
        if ({token_clear, false_alarm_cnt} !== {1'b1, exp_fa}) begin
            miscompares++;
            $display("FAIL timeout_clear: got clr=%b fa=%0d, required clr=1 fa=%0d", token_clear, false_alarm_cnt, exp_fa);
        end
        tick();
        @(negedge clock);
        vectors++;
        if ({token_clear, dl_detect_out, rpt.report_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL timeout_idle: got clr=%b det=%b rv=%b, required all 0", token_clear, dl_detect_out, rpt.report_valid);
        end
        $display("timeout origin=%b false_alarm_cnt=%0d", launch, false_alarm_cnt);
    endtask

    task automatic test_return_on_timeout();
        rpt.report_ready = 1'b0;
        tick();
        dl_in_vec = 4'b0001;
        tick();
        tick();
        dl_in_vec = 4'b0000;
        trace_vld_vec = 4'b0001;
        tick();
        trace_vld_vec = 4'b0000;
        @(negedge clock);
        vectors++;
        if ({dl_detect_out, rpt.report_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL launch_strobe: got det=%b rv=%b, required det=1 rv=0", dl_detect_out, rpt.report_valid);
        end
        repeat (62) tick();
        trace_vld_vec = 4'b0101;
        exp_q.push_back('{org: 2'd0, mask: 4'b0101, len: 3'd2});
        tick();
        trace_vld_vec = 4'b0000;
        @(negedge clock);
        vectors++;
        if ({rpt.report_valid, token_clear, false_alarm_cnt} !== {1'b1, 1'b0, exp_fa}) begin
            miscompares++;
            $display("FAIL return_wins: got rv=%b clr=%b fa=%0d, required rv=1 clr=0 fa=%0d",
                     rpt.report_valid, token_clear, false_alarm_cnt, exp_fa);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clock);
            vectors++;
            if ({rpt.report_valid, rpt.report_origin, rpt.report_mask, rpt.report_len, dl_detect_out}
                    !== {1'b1, 2'd0, 4'b0101, 3'd2, 1'b1}) begin
                miscompares++;
                $display("FAIL report_hold: cycle %0d got rv=%b ro=%0d rm=%b rl=%0d det=%b, required rv=1 ro=0 rm=0101 rl=2 det=1",
                         i, rpt.report_valid, rpt.report_origin, rpt.report_mask, rpt.report_len, dl_detect_out);
            end
        end
        tick();
        rpt.report_ready = 1'b1;
        tick();
        @(negedge clock);
        vectors++;
        if ({token_clear, rpt.report_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL held_release: got clr=%b rv=%b, required clr=1 rv=0", token_clear, rpt.report_valid);
        end
        tick();
    endtask

    task automatic test_reset_mid_report();
        rpt.report_ready = 1'b0;
        tick();
        dl_in_vec = 4'b0010;
        tick();
        tick();
        dl_in_vec = 4'b0000;
        tick();
        trace_vld_vec = 4'b0010;
        tick();
        trace_vld_vec = 4'b0000;
        @(negedge clock);
        vectors++;
        if (rpt.report_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_report: got rv=%b, required 1", rpt.report_valid);
        end
        #2;
        reset = 1'b0;
        exp_fa = 2'd0;
        #1;
        vectors++;
        if ({dl_detect_out, origin, token_clear, rpt.report_valid, rpt.report_origin,
             rpt.report_mask, rpt.report_len, deadlock_seen, false_alarm_cnt} !== 20'd0) begin
            miscompares++;
            $display("FAIL async_reset: got det=%b org=%b clr=%b rv=%b ro=%0d rm=%b rl=%0d seen=%b fa=%0d, required all 0",
                     dl_detect_out, origin, token_clear, rpt.report_valid, rpt.report_origin,
                     rpt.report_mask, rpt.report_len, deadlock_seen, false_alarm_cnt);
        end
        @(negedge clock);
        reset = 1'b1;
        repeat (3) tick();
        @(negedge clock);
        vectors++;
        if ({dl_detect_out, token_clear, rpt.report_valid, deadlock_seen} !== 4'b0000) begin
            miscompares++;
            $display("FAIL post_reset_idle: got det=%b clr=%b rv=%b seen=%b, required all 0",
                     dl_detect_out, token_clear, rpt.report_valid, deadlock_seen);
        end
        $display("reset mid-report abandoned");
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_trace_report();
        test_confirm_restart();
        test_timeout(4'b1000);
        test_timeout(4'b0100);
        test_timeout(4'b0001);
        test_timeout(4'b0010);
        test_return_on_timeout();
        test_reset_mid_report();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d reports outstanding, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
